fetch_mem_arbiter: RTL and testbench



---
 rtl/toy_pack.sv | 24 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/fetch_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_fetch_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_pack.sv
// -----------------------------------------------------------------------------
// toy_pack
// Shared definitions for the instruction-fetch memory arbiter.
//   - Default widths for address, tag and fetch data.
//   - Source encodings carried in the MSB of the memory-side tag.
//   - fetch_arb_req_t: payload held in the arbiter's request register. It is
//     sized at the default widths, so ADDR_W/TAG_W must not exceed them.
// -----------------------------------------------------------------------------
package toy_pack;

  localparam int ADDR_WIDTH       = 32;
  localparam int FETCH_DATA_WIDTH = 256;
  localparam int FETCH_ARB_TAG_W  = 12;

  localparam logic FETCH_ARB_SRC_DEMAND   = 1'b0;
  localparam logic FETCH_ARB_SRC_PREFETCH = 1'b1;

  typedef struct packed {
    logic                       src;
    logic [ADDR_WIDTH-1:0]      addr;
    logic [FETCH_ARB_TAG_W-1:0] tag;
  } fetch_arb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant. On a tie the requester not granted last wins;
// a lone requester always wins. rr_last only moves when a grant is taken.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (rr_last resets to 1 so
//               requester 0 wins the first tie)
//   req[1:0]    request vector
//   advance     the current grant is taken this cycle
//   gnt[1:0]    one-hot grant (all zero when nothing requests)
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic rr_last;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    gnt = req;
    if (&req) gnt = rr_last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n)                rr_last <= 1'b1;
    else if (advance && |gnt)  rr_last <= gnt[1];
  end

endmodule

// File: rtl/fetch_mem_arbiter.sv
// -----------------------------------------------------------------------------
// fetch_mem_arbiter
// Shares the instruction-fetch memory port between the ICache demand path
// (port 0) and the prefetcher (port 1). Requests pass through a single
// registered stage; an outstanding-transaction credit counter limits the
// number of accepted-but-unanswered requests; responses are routed back
// combinationally by the source bit placed in the MSB of the memory tag.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req{0,1}_vld/rdy/addr/tag        requester side (hold until rdy)
//   mem_req_vld/rdy/addr/tag         registered request to memory, tag = {src, tag}
//   mem_ack_vld/rdy/data/tag         response from memory (may be out of order)
//   rsp{0,1}_vld/rdy/data/tag        routed response, source bit stripped
//   perf_*_cnt                       saturating counters, only when the macro
//                                    FETCH_MEM_ARB_PERF_EN is defined
// MAX_OUTSTANDING legal range is 1..15.
// -----------------------------------------------------------------------------
module fetch_mem_arbiter
  import toy_pack::*;
#(
  parameter int ADDR_W          = ADDR_WIDTH,
  parameter int TAG_W           = FETCH_ARB_TAG_W,
  parameter int DATA_W          = FETCH_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_vld,
  output logic              req0_rdy,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_vld,
  output logic              req1_rdy,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              mem_req_vld,
  input  logic              mem_req_rdy,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [TAG_W:0]    mem_req_tag,
  input  logic              mem_ack_vld,
  output logic              mem_ack_rdy,
  input  logic [DATA_W-1:0] mem_ack_data,
  input  logic [TAG_W:0]    mem_ack_tag,
  output logic              rsp0_vld,
  input  logic              rsp0_rdy,
  output logic [DATA_W-1:0] rsp0_data,
  output logic [TAG_W-1:0]  rsp0_tag,
  output logic              rsp1_vld,
  input  logic              rsp1_rdy,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [TAG_W-1:0]  rsp1_tag
`ifdef FETCH_MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_grant0_cnt,
  output logic [31:0]       perf_grant1_cnt,
  output logic [31:0]       perf_credit_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0] credit_cnt;
  logic             req_q_vld;
  fetch_arb_req_t   req_q;
  fetch_arb_req_t   req_d;
  logic [1:0]       gnt;
  logic             ack_hs;
  logic             credit_dec;
  logic             credit_ok;
  logic             drain;
  logic             can_load;
  logic             load;
  logic             ack_src;

  // Response side. A response with no credits outstanding is a protocol
  // error; the counter simply refuses to go below zero.
  assign ack_hs     = mem_ack_vld && mem_ack_rdy;
  assign credit_dec = ack_hs && (credit_cnt != '0);

  // A same-cycle response frees its credit in time for a new grant.
  assign credit_ok  = (int'(credit_cnt) - int'(credit_dec)) < MAX_OUTSTANDING;
  assign drain      = req_q_vld && mem_req_rdy;
  // rst_n gating keeps rdy low while in reset.
  assign can_load   = rst_n && (!req_q_vld || drain) && credit_ok;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1_vld, req0_vld}),
    .advance (can_load),
    .gnt     (gnt)
  );

  assign req0_rdy = can_load && gnt[0];
  assign req1_rdy = can_load && gnt[1];
  assign load     = req0_rdy || req1_rdy;

  always_comb begin
    req_d.src  = FETCH_ARB_SRC_DEMAND;
    req_d.addr = ADDR_WIDTH'(req0_addr);
    req_d.tag  = FETCH_ARB_TAG_W'(req0_tag);
    if (gnt[1]) begin
      req_d.src  = FETCH_ARB_SRC_PREFETCH;
      req_d.addr = ADDR_WIDTH'(req1_addr);
      req_d.tag  = FETCH_ARB_TAG_W'(req1_tag);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q_vld  <= 1'b0;
      credit_cnt <= '0;
    end else begin
      if (load)       req_q_vld <= 1'b1;
      else if (drain) req_q_vld <= 1'b0;

      case ({load, credit_dec})
        2'b10:   credit_cnt <= credit_cnt + CNT_W'(1);
        2'b01:   credit_cnt <= credit_cnt - CNT_W'(1);
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  // NOTE: the payload is qualified by req_q_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load) req_q <= req_d;
  end

  assign mem_req_vld  = req_q_vld;
  assign mem_req_addr = req_q.addr[ADDR_W-1:0];
  assign mem_req_tag  = {req_q.src, req_q.tag[TAG_W-1:0]};

  // Combinational response routing; data and tag go to both requesters.
  assign ack_src     = mem_ack_tag[TAG_W];
  assign rsp0_vld    = mem_ack_vld && (ack_src == FETCH_ARB_SRC_DEMAND);
  assign rsp1_vld    = mem_ack_vld && (ack_src == FETCH_ARB_SRC_PREFETCH);
  assign mem_ack_rdy = ack_src ? rsp1_rdy : rsp0_rdy;
  assign rsp0_data   = mem_ack_data;
  assign rsp1_data   = mem_ack_data;
  assign rsp0_tag    = mem_ack_tag[TAG_W-1:0];
  assign rsp1_tag    = mem_ack_tag[TAG_W-1:0];

  a_no_ack_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(ack_hs && credit_cnt == '0));

`ifdef FETCH_MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_grant0_cnt       <= '0;
      perf_grant1_cnt       <= '0;
      perf_credit_stall_cnt <= '0;
    end else begin
      if (req0_rdy && !(&perf_grant0_cnt)) perf_grant0_cnt <= perf_grant0_cnt + 32'd1;
      if (req1_rdy && !(&perf_grant1_cnt)) perf_grant1_cnt <= perf_grant1_cnt + 32'd1;
      if ((req0_vld || req1_vld) && !credit_ok && !(&perf_credit_stall_cnt))
        perf_credit_stall_cnt <= perf_credit_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fetch_mem_arbiter
// Directed bench for fetch_mem_arbiter with MAX_OUTSTANDING=2. Expected memory
// requests and routed responses are queued by the stimulus; a negedge monitor
// pops and compares them whenever a handshake is visible.
// -----------------------------------------------------------------------------
module tb_fetch_mem_arbiter;

  localparam int AW = 32;
  localparam int TW = 12;
  localparam int DW = 256;

  typedef struct { logic [AW-1:0] addr; logic [TW-1:0] tag; } req_t;
  typedef struct { logic [AW-1:0] addr; logic [TW:0]   tag; } mreq_t;
  typedef struct { logic src; logic [TW-1:0] tag; logic [DW-1:0] data; } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_vld = 1'b0, req1_vld = 1'b0;
  logic          req0_rdy, req1_rdy;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [TW-1:0] req0_tag = '0, req1_tag = '0;
  logic          mem_req_vld;
  logic          mem_req_rdy = 1'b0;
  logic [AW-1:0] mem_req_addr;
  logic [TW:0]   mem_req_tag;
  logic          mem_ack_vld = 1'b0;
  logic          mem_ack_rdy;
  logic [DW-1:0] mem_ack_data = '0;
  logic [TW:0]   mem_ack_tag = '0;
  logic          rsp0_vld, rsp1_vld;
  logic          rsp0_rdy = 1'b0, rsp1_rdy = 1'b0;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic [TW-1:0] rsp0_tag, rsp1_tag;

  int checks = 0;
  int errors = 0;

  req_t  drv_q0[$], drv_q1[$];
  mreq_t exp_mem_q[$];
  rsp_t  exp_rsp_q[$];
  mreq_t ack_q[$];
  bit    auto_ack = 1'b0;

  bit            hs0, hs1, mem_hs_s, ack_hs_s;
  logic [AW-1:0] mem_hs_addr;
  logic [TW:0]   mem_hs_tag;

  fetch_mem_arbiter #(
    .ADDR_W(AW), .TAG_W(TW), .DATA_W(DW), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_addr(req0_addr), .req0_tag(req0_tag),
    .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_addr(req1_addr), .req1_tag(req1_tag),
    .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_ack_vld(mem_ack_vld), .mem_ack_rdy(mem_ack_rdy),
    .mem_ack_data(mem_ack_data), .mem_ack_tag(mem_ack_tag),
    .rsp0_vld(rsp0_vld), .rsp0_rdy(rsp0_rdy), .rsp0_data(rsp0_data), .rsp0_tag(rsp0_tag),
    .rsp1_vld(rsp1_vld), .rsp1_rdy(rsp1_rdy), .rsp1_data(rsp1_data), .rsp1_tag(rsp1_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [DW-1:0] rsp_data(logic [AW-1:0] a);
    return {8{a}};
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rsp_seen(bit src, logic [TW-1:0] tag, logic [DW-1:0] data);
    rsp_t e;
    check("rsp_expected", exp_rsp_q.size() != 0, 1);
    if (exp_rsp_q.size() != 0) begin
      e = exp_rsp_q.pop_front();
      check("rsp_src", src, e.src);
      check("rsp_tag", tag, e.tag);
      check("rsp_data", data, e.data);
    end
  endtask

  // Monitor: samples mid-cycle, scoreboards memory requests and responses.
  always @(negedge clk) begin
    mreq_t e;
    hs0         = req0_vld && req0_rdy;
    hs1         = req1_vld && req1_rdy;
    ack_hs_s    = mem_ack_vld && mem_ack_rdy;
    mem_hs_s    = mem_req_vld && mem_req_rdy;
    mem_hs_addr = mem_req_addr;
    mem_hs_tag  = mem_req_tag;
    if (mem_hs_s) begin
      check("mem_expected", exp_mem_q.size() != 0, 1);
      if (exp_mem_q.size() != 0) begin
        e = exp_mem_q.pop_front();
        check("mem_addr", mem_req_addr, e.addr);
        check("mem_tag", mem_req_tag, e.tag);
      end
    end
    if (rsp0_vld && rsp0_rdy) rsp_seen(1'b0, rsp0_tag, rsp0_data);
    if (rsp1_vld && rsp1_rdy) rsp_seen(1'b1, rsp1_tag, rsp1_data);
  end

  // One clock: requester drivers and the optional auto-responding memory.
  task automatic tick();
    @(posedge clk);
    #1;
    if (hs0 && drv_q0.size() != 0) void'(drv_q0.pop_front());
    if (hs1 && drv_q1.size() != 0) void'(drv_q1.pop_front());
    req0_vld = drv_q0.size() != 0;
    if (req0_vld) begin req0_addr = drv_q0[0].addr; req0_tag = drv_q0[0].tag; end
    req1_vld = drv_q1.size() != 0;
    if (req1_vld) begin req1_addr = drv_q1[0].addr; req1_tag = drv_q1[0].tag; end
    if (auto_ack) begin
      if (ack_hs_s && ack_q.size() != 0) void'(ack_q.pop_front());
      if (mem_hs_s) ack_q.push_back('{addr: mem_hs_addr, tag: mem_hs_tag});
      mem_ack_vld = ack_q.size() != 0;
      if (mem_ack_vld) begin
        mem_ack_tag  = ack_q[0].tag;
        mem_ack_data = rsp_data(ack_q[0].addr);
      end
    end
  endtask

  task automatic push_req(bit port, logic [AW-1:0] a, logic [TW-1:0] t);
    if (port) drv_q1.push_back('{addr: a, tag: t});
    else      drv_q0.push_back('{addr: a, tag: t});
  endtask

  task automatic expect_mem(logic [AW-1:0] a, logic [TW:0] t);
    exp_mem_q.push_back('{addr: a, tag: t});
  endtask

  task automatic expect_rsp(logic [TW:0] t, logic [AW-1:0] a);
    exp_rsp_q.push_back('{src: t[TW], tag: t[TW-1:0], data: rsp_data(a)});
  endtask

  task automatic ack(logic [TW:0] t, logic [AW-1:0] a);
    mem_ack_vld  = 1'b1;
    mem_ack_tag  = t;
    mem_ack_data = rsp_data(a);
    expect_rsp(t, a);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_mem_q.size() + exp_rsp_q.size()) != 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain", exp_mem_q.size() + exp_rsp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    auto_ack = 1'b0;
    drv_q0.delete(); drv_q1.delete();
    exp_mem_q.delete(); exp_rsp_q.delete(); ack_q.delete();
    mem_req_rdy = 1'b0; mem_ack_vld = 1'b0;
    rsp0_rdy = 1'b0; rsp1_rdy = 1'b0;
    tick();
    req0_vld = 1'b1; req1_vld = 1'b1;
    #1;
    check("rst_mem_req_vld", mem_req_vld, 0);
    check("rst_req0_rdy", req0_rdy, 0);
    check("rst_req1_rdy", req1_rdy, 0);
    check("rst_credit", dut.credit_cnt, 0);
    req0_vld = 1'b0; req1_vld = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    // Tie from reset: grant order 0,1,0,1 with an auto-acking memory.
    do_reset();
    mem_req_rdy = 1'b1; rsp0_rdy = 1'b1; rsp1_rdy = 1'b1; auto_ack = 1'b1;
    push_req(0, 32'h100, 12'h001); push_req(0, 32'h104, 12'h002);
    push_req(1, 32'h200, 12'h011); push_req(1, 32'h204, 12'h012);
    expect_mem(32'h100, 13'h0001); expect_rsp(13'h0001, 32'h100);
    expect_mem(32'h200, 13'h1011); expect_rsp(13'h1011, 32'h200);
    expect_mem(32'h104, 13'h0002); expect_rsp(13'h0002, 32'h104);
    expect_mem(32'h204, 13'h1012); expect_rsp(13'h1012, 32'h204);
    wait_drain();
    check("tie_credit_end", dut.credit_cnt, 0);
    auto_ack = 1'b0; mem_ack_vld = 1'b0;

    // Single demand request: one-cycle latency, credit 0 -> 1.
    do_reset();
    mem_req_rdy = 1'b1; rsp0_rdy = 1'b1;
    push_req(0, 32'h1000, 12'h005);
    expect_mem(32'h1000, 13'h0005);
    tick(); #1;
    check("single_rdy", req0_rdy, 1);
    check("single_credit0", dut.credit_cnt, 0);
    tick(); #1;
    check("single_mem_vld", mem_req_vld, 1);
    check("single_mem_tag", mem_req_tag, 13'h0005);
    check("single_mem_addr", mem_req_addr, 32'h1000);
    check("single_credit1", dut.credit_cnt, 1);
    ack(13'h0005, 32'h1000); #1;
    check("single_ack_rdy", mem_ack_rdy, 1);
    check("single_rsp0_vld", rsp0_vld, 1);
    tick(); mem_ack_vld = 1'b0; #1;
    check("single_credit_back", dut.credit_cnt, 0);

    // Credit stall at MAX=2, then grant in the same cycle as a response.
    push_req(0, 32'h2000, 12'h021); push_req(0, 32'h2004, 12'h022);
    push_req(0, 32'h2008, 12'h023);
    expect_mem(32'h2000, 13'h0021); expect_mem(32'h2004, 13'h0022);
    expect_mem(32'h2008, 13'h0023);
    tick(); #1; check("stall_rdy_e", req0_rdy, 1);
    tick(); #1; check("stall_rdy_f", req0_rdy, 1);
    check("stall_credit1", dut.credit_cnt, 1);
    tick(); #1; check("stall_rdy_g0", req0_rdy, 0);
    check("stall_credit2", dut.credit_cnt, 2);
    tick(); #1; check("stall_rdy_g1", req0_rdy, 0);
    ack(13'h0021, 32'h2000); #1;
    check("stall_rdy_on_ack", req0_rdy, 1);
    check("stall_ack_rdy", mem_ack_rdy, 1);
    tick(); mem_ack_vld = 1'b0; #1;
    check("credit_hold_at_max", dut.credit_cnt, 2);
    check("stall_g_loaded", mem_req_tag, 13'h0023);
    ack(13'h0022, 32'h2004);
    tick(); ack(13'h0023, 32'h2008);
    tick(); mem_ack_vld = 1'b0; #1;
    check("stall_credit_end", dut.credit_cnt, 0);
    wait_drain();

    // Back-pressure: request held for 5 cycles, no further grants.
    mem_req_rdy = 1'b0;
    push_req(1, 32'h3000, 12'h00A); push_req(0, 32'h3100, 12'h032);
    expect_mem(32'h3000, 13'h100A); expect_mem(32'h3100, 13'h0032);
    tick(); #1;
    check("hold_rdy1", req1_rdy, 1);
    check("hold_rdy0", req0_rdy, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      check("hold_vld", mem_req_vld, 1);
      check("hold_addr", mem_req_addr, 32'h3000);
      check("hold_tag", mem_req_tag, 13'h100A);
      check("hold_no_rdy0", req0_rdy, 0);
    end
    mem_req_rdy = 1'b1; #1;
    check("hold_release_rdy0", req0_rdy, 1);
    tick(); tick();
    mem_req_rdy = 1'b0;

    // Prefetch response routing with back-pressure from requester 1.
    mem_ack_vld = 1'b1; mem_ack_tag = 13'h100A; mem_ack_data = rsp_data(32'h3000);
    rsp1_rdy = 1'b0; rsp0_rdy = 1'b1; #1;
    check("route_rsp1_vld", rsp1_vld, 1);
    check("route_rsp0_vld", rsp0_vld, 0);
    check("route_rsp1_tag", rsp1_tag, 12'h00A);
    check("route_rsp0_tag", rsp0_tag, 12'h00A);
    check("route_rsp1_data", rsp1_data, rsp_data(32'h3000));
    check("route_ack_rdy0", mem_ack_rdy, 0);
    tick(); #1;
    check("route_rsp1_hold", rsp1_vld, 1);
    check("route_ack_rdy_hold", mem_ack_rdy, 0);
    rsp1_rdy = 1'b1; ack(13'h100A, 32'h3000); #1;
    check("route_ack_rdy1", mem_ack_rdy, 1);
    tick(); ack(13'h0032, 32'h3100);
    tick(); mem_ack_vld = 1'b0; #1;
    check("route_credit_end", dut.credit_cnt, 0);
    wait_drain();

    // Reset in the middle of a stalled request.
    push_req(0, 32'h4000, 12'h044);
    tick(); tick(); #1;
    check("midrst_vld_before", mem_req_vld, 1);
    check("midrst_credit_before", dut.credit_cnt, 1);
    do_reset();
    tick(); #1;
    check("midrst_vld_after", mem_req_vld, 0);

    check("final_queues", exp_mem_q.size() + exp_rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
